// File: rtl/iter_carry_select_adder.sv
// Sequential carry-select adder/subtractor: one BLOCK-bit slice per clock,
// both carry candidates formed per slice and chosen by the registered carry.
module iter_carry_select_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int BSAFE  = (BLOCK >= 1) ? BLOCK : 1;
    localparam int NSLICE = WIDTH / BSAFE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if ((BLOCK < 1) || ((WIDTH % BSAFE) != 0)) begin : g_bad_cfg
        $error("iter_carry_select_adder: WIDTH must be a positive multiple of BLOCK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic [IW-1:0]    w_base;
    logic [BLOCK-1:0] w_ai;
    logic [BLOCK-1:0] w_bi;
    logic [BLOCK:0]   w_s0;
    logic [BLOCK:0]   w_s1;
    logic [BLOCK:0]   w_sel;
    logic             w_last;
    logic             w_cmsb;
    logic             w_accept;

    // Slice base never exceeds WIDTH-BLOCK, so IW-bit arithmetic is exact.
    always_comb begin
        w_base = IW'(r_cnt) * IW'(BLOCK);
        w_ai   = r_a[w_base +: BLOCK];
        w_bi   = r_b[w_base +: BLOCK];
        w_s0   = {1'b0, w_ai} + {1'b0, w_bi};
        w_s1   = w_s0 + (BLOCK + 1)'(1);
        w_sel  = r_carry ? w_s1 : w_s0;
        w_last = (r_cnt == CW'(NSLICE - 1));
        // sum bit = a ^ b ^ carry_in, so the carry into the slice MSB falls out directly.
        w_cmsb = w_sel[BLOCK-1] ^ w_ai[BLOCK-1] ^ w_bi[BLOCK-1];
    end

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub | c_in;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_sum[w_base +: BLOCK] <= w_sel[BLOCK-1:0];
                r_carry                <= w_sel[BLOCK];
                r_cnt                  <= r_cnt + CW'(1);
                if (w_last) begin
                    r_cout <= w_sel[BLOCK];
                    r_ovf  <= w_cmsb ^ w_sel[BLOCK];
                end
            end
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign sum      = r_sum;
    assign c_out    = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_iter_carry_select_adder.sv
// Directed and random checks of iter_carry_select_adder in three slice configurations.
module tb_iter_carry_select_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st8 = 0, sub8 = 0, c8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       busy8, done8, co8, ov8;
    logic [7:0] sum8;

    logic        st16 = 0, sub16 = 0, ci16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        busy1, done1, co1, ov1, busyF, doneF, coF, ovF;
    logic [15:0] sum1, sumF;

    iter_carry_select_adder #(.WIDTH(8), .BLOCK(4)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .sub(sub8), .a(a8), .b(b8), .c_in(c8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(co8), .overflow(ov8));
    iter_carry_select_adder #(.WIDTH(16), .BLOCK(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(st16), .sub(sub16), .a(a16), .b(b16), .c_in(ci16),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(co1), .overflow(ov1));
    iter_carry_select_adder #(.WIDTH(16), .BLOCK(16)) u_dF (
        .clk(clk), .rst_n(rst_n), .start(st16), .sub(sub16), .a(a16), .b(b16), .c_in(ci16),
        .busy(busyF), .done(doneF), .sum(sumF), .c_out(coF), .overflow(ovF));

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: {c_out, overflow, sum}
    function automatic logic [9:0] m8(input logic s, input logic [7:0] x, input logic [7:0] y,
                                      input logic ci);
        logic [7:0] yy;
        logic [8:0] t;
        logic       ov;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {8'b0, (s | ci)};
        ov = (x[7] == yy[7]) && (t[7] != x[7]);
        return {t[8], ov, t[7:0]};
    endfunction

    function automatic logic [17:0] m16(input logic s, input logic [15:0] x, input logic [15:0] y,
                                        input logic ci);
        logic [15:0] yy;
        logic [16:0] t;
        logic        ov;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {16'b0, (s | ci)};
        ov = (x[15] == yy[15]) && (t[15] != x[15]);
        return {t[16], ov, t[15:0]};
    endfunction

    // One 8-bit operation; lat = negedges after the accept edge until done is seen.
    task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y, input logic ci,
                       output int lat, output int nbusy, output int both);
        int k;
        @(negedge clk);
        st8 = 1; sub8 = s; a8 = x; b8 = y; c8 = ci;
        @(negedge clk);
        st8 = 0; sub8 = ~s; a8 = ~x; b8 = ~y; c8 = ~ci;
        k = 1; nbusy = 0; both = 0;
        while (k <= 40 && !done8) begin
            if (busy8) nbusy++;
            @(negedge clk);
            k++;
        end
        if (busy8 && done8) both++;
        lat = done8 ? k : -1;
    endtask

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t        tbl[10];
    vec_t        bb[4];
    int          lat, nb, both, k, nd, idx, prev, l1, lF;
    logic [9:0]  e8;
    logic [17:0] e16, r1, rF;

    initial begin
        tbl[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 8'h55, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0};
        bb[0]  = '{1'b0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0};
        bb[1]  = '{1'b1, 8'h10, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0};
        bb[2]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0};
        bb[3]  = '{1'b1, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst8_ctl", 32'({busy8, done8, co8, ov8}), 32'h0);
        chk("rst8_sum", 32'(sum8), 32'h0);
        chk("rst1", 32'({busy1, done1, co1, ov1, sum1}), 32'h0);
        chk("rstF", 32'({busyF, doneF, coF, ovF, sumF}), 32'h0);
        rst_n = 1;

        // Directed table, 8-bit / 4-bit slices
        for (int i = 0; i < 10; i++) begin
            op8(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, lat, nb, both);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd3);
            chk($sformatf("tbl%0d_busy", i), 32'(nb), 32'd2);
            chk($sformatf("tbl%0d_both", i), 32'(both), 32'd0);
            chk($sformatf("tbl%0d_res", i), 32'({co8, ov8, sum8}),
                32'({tbl[i].co, tbl[i].ov, tbl[i].s}));
        end

        // start with other operands during RUN is ignored
        @(negedge clk);
        st8 = 1; sub8 = 0; a8 = 8'h7F; b8 = 8'h00; c8 = 1;
        @(negedge clk);
        st8 = 1; sub8 = 1; a8 = 8'h11; b8 = 8'h22; c8 = 0;
        @(negedge clk);
        chk("ign_busy", 32'({busy8, done8}), 32'h2);
        st8 = 0;
        @(negedge clk);
        chk("ign_done", 32'(done8), 32'd1);
        chk("ign_res", 32'({co8, ov8, sum8}), 32'({1'b0, 1'b1, 8'h80}));
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("ign_onepulse", 32'(nd), 32'd0);
        chk("ign_hold", 32'({co8, ov8, sum8}), 32'({1'b0, 1'b1, 8'h80}));

        // Reset in the second RUN cycle
        @(negedge clk);
        st8 = 1; sub8 = 0; a8 = 8'h12; b8 = 8'h34; c8 = 0;
        @(negedge clk);
        st8 = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("mrst_ctl", 32'({busy8, done8, co8, ov8}), 32'h0);
        chk("mrst_sum", 32'(sum8), 32'h0);
        rst_n = 1;
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done8 || busy8) nd++;
        end
        chk("mrst_nodone", 32'(nd), 32'd0);
        op8(1'b0, 8'h12, 8'h34, 1'b0, lat, nb, both);
        chk("mrst_lat", 32'(lat), 32'd3);
        chk("mrst_res", 32'({co8, ov8, sum8}), 32'({1'b0, 1'b0, 8'h46}));

        // Back-to-back with start held high
        @(negedge clk);
        st8 = 1; sub8 = bb[0].sub; a8 = bb[0].a; b8 = bb[0].b; c8 = bb[0].cin;
        idx = 0; prev = -1; k = 0;
        while (k < 40 && idx < 4) begin
            @(negedge clk);
            k++;
            if (done8) begin
                e8 = m8(bb[idx].sub, bb[idx].a, bb[idx].b, bb[idx].cin);
                chk($sformatf("b2b%0d_res", idx), 32'({co8, ov8, sum8}), 32'(e8));
                if (prev >= 0) chk($sformatf("b2b%0d_gap", idx), 32'(k - prev), 32'd3);
                else chk("b2b0_lat", 32'(k), 32'd3);
                prev = k;
                idx++;
                if (idx < 4) begin
                    sub8 = bb[idx].sub; a8 = bb[idx].a; b8 = bb[idx].b; c8 = bb[idx].cin;
                end else begin
                    st8 = 0;
                end
            end
        end
        chk("b2b_count", 32'(idx), 32'd4);
        @(negedge clk);
        chk("b2b_idle", 32'({busy8, done8}), 32'h0);

        // Random vectors on BLOCK=1 and BLOCK=16 (16-bit)
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            sub16 = 1'($urandom_range(0, 1));
            ci16  = 1'($urandom_range(0, 1));
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            if (n < 4) begin
                a16 = (n < 2) ? 16'h7FFF : 16'h8000;
                b16 = (n[0]) ? 16'hFFFF : 16'h0001;
            end
            e16 = m16(sub16, a16, b16, ci16);
            st16 = 1;
            @(negedge clk);
            st16 = 0; a16 = ~a16; b16 = ~b16; sub16 = ~sub16; ci16 = ~ci16;
            k = 1; l1 = 0; lF = 0; r1 = '0; rF = '0;
            while (k <= 24 && (l1 == 0 || lF == 0)) begin
                if (done1 && l1 == 0) begin l1 = k; r1 = {co1, ov1, sum1}; end
                if (doneF && lF == 0) begin lF = k; rF = {coF, ovF, sumF}; end
                if (l1 == 0 || lF == 0) begin
                    @(negedge clk);
                    k++;
                end
            end
            chk($sformatf("rnd%0d_lat_b1", n), 32'(l1), 32'd17);
            chk($sformatf("rnd%0d_lat_b16", n), 32'(lF), 32'd2);
            chk($sformatf("rnd%0d_res_b1", n), 32'(r1), 32'(e16));
            chk($sformatf("rnd%0d_res_b16", n), 32'(rF), 32'(e16));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/iter_carry_select_adder.md
Name: iter_carry_select_adder

Overview:
Multi-cycle, parametrised carry-select adder/subtractor. It processes one BLOCK-bit slice per clock. For each slice it computes both carry-0 and carry-1 candidate sums, then selects between them using the registered carry from the previous slice. It is the sequential, width-generic successor to the gate-level full-adder and carry-select datapath, and is intended for ALU-style use behind a start/done handshake.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of BLOCK.
BLOCK, 4, slice width processed per cycle; 1 <= BLOCK <= WIDTH.
(derived) NSLICE = WIDTH/BLOCK; slice counter width = max(1, clog2(NSLICE)).

Ports:
clk  in  1  rising-edge clock, the only clock.
rst_n  in  1  synchronous, active-low reset.
start  in  1  request; sampled only in IDLE or DONE.
sub  in  1  0 = a+b+c_in; 1 = a-b (computed as a+~b+1, c_in ignored); sampled with start.
a  in  WIDTH  operand A; sampled with start.
b  in  WIDTH  operand B; sampled with start.
c_in  in  1  carry in for add mode; sampled with start.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse; results are valid on that cycle.
sum  out  WIDTH  result; holds from done until the next accepted start.
c_out  out  1  carry out of the MSB (sub mode: 1 = no borrow).
overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: the clock and reset are one clock, rst_n synchronous active-low. When rst_n=0 at an edge: state=IDLE; busy, done, sum, c_out, overflow, the slice counter, the carry register and the operand registers all go to 0. Reset wins over every other event, including mid-RUN; the partial result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge: latch A=a, B=(sub ? ~b : b), carry=(sub ? 1 : c_in); counter=0; go to RUN. With start=0, stay in IDLE.
- RUN, each edge, slice i=counter covering bits [i*BLOCK +: BLOCK]:
  - s0 = A_i+B_i+0 and s1 = A_i+B_i+1, each BLOCK+1 bits wide.
  - Select s1 if carry=1, else s0.
  - Write the low BLOCK bits into sum[i*BLOCK +: BLOCK]; carry <= the selected MSB.
  - On the last slice (i=NSLICE-1): c_out <= selected carry; overflow <= (carry into bit WIDTH-1) XOR (selected carry). The carry into bit WIDTH-1 is computed inside that slice; when BLOCK=1 it is the carry register.
  - counter increments; after the last slice go to DONE.
- DONE: lasts exactly one cycle with done=1, then returns to IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); done still deasserts on the next cycle.
- start during RUN is ignored, and operands/sub/c_in changes during RUN have no effect.
- Latency: start accepted at edge 0; busy=1 from after edge 0 through edge NSLICE; done=1 during the cycle after edge NSLICE. Total NSLICE+1 cycles from start to done; throughput is one operation per NSLICE+1 cycles.
- During RUN, sum is partially updated and is valid only when done=1. sum, c_out and overflow hold their values after DONE until the next accepted start. The upper slices of sum are not cleared at start; they are overwritten during RUN.
- busy and done are registered outputs (state decodes) and are never high together.
- All arithmetic is unsigned modulo 2^WIDTH; overflow interprets operands as two's complement.
- Elaboration must fail if WIDTH % BLOCK != 0 or BLOCK < 1.

Test Plan:
1. WIDTH=8, BLOCK=4, add: a=8'hFF, b=8'h01, c_in=0 -> done 3 cycles after start; sum=8'h00, c_out=1, overflow=0; busy high for exactly 2 cycles.
2. WIDTH=8, BLOCK=4, sub: a=8'h80, b=8'h01 -> sum=8'h7F, c_out=1, overflow=1. Then a=8'h00, b=8'h01 -> sum=8'hFF, c_out=0, overflow=0.
3. Add with c_in=1: a=8'h7F, b=8'h00 -> sum=8'h80, overflow=1, c_out=0. Assert start again with different operands during RUN -> ignored; result unchanged and exactly one done pulse.
4. Reset mid-op: assert rst_n=0 in the second RUN cycle -> next cycle busy=0, done=0, sum=0, c_out=0, overflow=0. No done pulse follows; a new start then completes normally.
5. Back-to-back: hold start=1 continuously -> done pulses every NSLICE+1 cycles, and each result matches the operands sampled at its own accept edge.
6. Configs WIDTH=16 with BLOCK=1 and BLOCK=16 (latencies 17 and 2 cycles): 1000 random add/sub vectors checked against a behavioural a+b+c_in / a-b model for sum, c_out and overflow.
